// File: rtl/pc_fetch_unit.sv
// Program-counter fetch front end: issues word-addressed instruction requests,
// folds branch redirects and exceptions into the PC, and kills stale fetches.
module pc_fetch_unit #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] INIT_ADDR  = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [ADDR_W-3:0] redir_addr,
  input  logic              exc_valid,
  output logic              imem_req,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic              imem_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-3:0] fetch_pc,
  output logic [ADDR_W-3:0] seq_pc
);

  localparam int PC_W = ADDR_W - 2;
  localparam logic [PC_W-1:0] INIT_PC = INIT_ADDR[ADDR_W-1:2];
  localparam logic [PC_W-1:0] EXC_PC  = EXC_VECTOR[ADDR_W-1:2];

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_exc_q, pend_exc_d;
  logic [PC_W-1:0]   pend_addr_q, pend_addr_d;

  logic              event_now;
  logic              any_event;
  logic              take_exc;
  logic              handshake;
  logic [PC_W-1:0]   target;

  // Natural overflow of the PC_W-bit sum gives the required wrap to zero.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

  assign seq_pc    = pc_incr(pc_q);
  assign event_now = exc_valid | redir_valid;
  assign any_event = event_now | pend_valid_q;
  assign take_exc  = exc_valid | (pend_valid_q & pend_exc_q);
  assign handshake = (state_q == ST_FETCH) & imem_ready;

  // A fresh redirect is newer than a pending one, so it takes precedence.
  always_comb begin
    target = seq_pc;
    if (take_exc) begin
      target = EXC_PC;
    end else if (redir_valid) begin
      target = redir_addr;
    end else if (pend_valid_q) begin
      target = pend_addr_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_exc_d   = pend_exc_q;
    pend_addr_d  = pend_addr_q;

    case (state_q)
      ST_BOOT: begin
        state_d = stall ? ST_HOLD : ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          pc_d         = target;
          pend_valid_d = 1'b0;
          state_d      = stall ? ST_HOLD : ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (any_event) begin
          pc_d         = target;
          pend_valid_d = 1'b0;
        end
        if (!stall) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Events that cannot act yet park in the single pending slot; a pending
    // exception is never displaced by a later redirect.
    if ((state_q == ST_BOOT) || ((state_q == ST_FETCH) && !imem_ready)) begin
      if (exc_valid) begin
        pend_valid_d = 1'b1;
        pend_exc_d   = 1'b1;
      end else if (redir_valid && !(pend_valid_q && pend_exc_q)) begin
        pend_valid_d = 1'b1;
        pend_exc_d   = 1'b0;
        pend_addr_d  = redir_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= INIT_PC;
      pend_valid_q <= 1'b0;
      pend_exc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_exc_q   <= pend_exc_d;
    end
  end

  // Pending target is only meaningful while pend_valid_q is set.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign fetch_valid = handshake & ~any_event;
  assign fetch_pc    = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit with a queue-based reference
// model, plus directed scenarios and a narrow-address wrap instance.
module tb_pc_fetch_unit;

  localparam int PW = 30;
  localparam logic [PW-1:0] EXC_W  = 30'h20;
  localparam logic [PW-1:0] INIT_W = 30'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, stall, redir_valid, exc_valid, imem_ready;
  logic [PW-1:0] redir_addr;
  logic          imem_req, fetch_valid;
  logic [PW-1:0] imem_addr, fetch_pc, seq_pc;

  logic       s_rst_n, s_stall, s_redir_valid, s_exc_valid, s_imem_ready;
  logic [5:0] s_redir_addr, s_imem_addr, s_fetch_pc, s_seq_pc;
  logic       s_imem_req, s_fetch_valid;

  pc_fetch_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redir_valid(redir_valid),
    .redir_addr(redir_addr), .exc_valid(exc_valid), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .seq_pc(seq_pc)
  );

  pc_fetch_unit #(.ADDR_W(8)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .stall(s_stall), .redir_valid(s_redir_valid),
    .redir_addr(s_redir_addr), .exc_valid(s_exc_valid), .imem_req(s_imem_req),
    .imem_addr(s_imem_addr), .imem_ready(s_imem_ready), .fetch_valid(s_fetch_valid),
    .fetch_pc(s_fetch_pc), .seq_pc(s_seq_pc)
  );

  typedef struct packed {
    logic          req;
    logic [PW-1:0] addr;
    logic          fv;
    logic [PW-1:0] fpc;
    logic [PW-1:0] seq;
  } exp_t;

  typedef struct packed {
    logic          is_exc;
    logic [PW-1:0] addr;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  int    m_mode;  // 0 boot, 1 fetching, 2 holding
  logic [PW-1:0] m_pc;

  int   checks = 0;
  int   errors = 0;
  logic last_fv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] m_next(input logic [PW-1:0] p);
    longint v;
    v = (longint'(p) + 1) % (longint'(1) << PW);
    return PW'(v);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc   = INIT_W;
    pend_q.delete();
  endtask

  task automatic model_latch(input logic ev, input logic rv, input logic [PW-1:0] ra);
    pend_t p;
    if (ev) begin
      p.is_exc = 1'b1;
      p.addr   = '0;
      pend_q.delete();
      pend_q.push_back(p);
    end else if (rv && !(pend_q.size() > 0 && pend_q[0].is_exc)) begin
      p.is_exc = 1'b0;
      p.addr   = ra;
      pend_q.delete();
      pend_q.push_back(p);
    end
  endtask

  // Called at posedge+1: drives one cycle of inputs, queues the expectation,
  // advances the model, and returns at the next posedge+1.
  task automatic cycle(input logic st, input logic rv, input logic [PW-1:0] ra,
                       input logic ev, input logic rdy);
    exp_t e;
    logic [PW-1:0] tgt;
    bit have_p, p_exc;
    stall = st; redir_valid = rv; redir_addr = ra; exc_valid = ev; imem_ready = rdy;
    have_p = (pend_q.size() > 0);
    p_exc  = have_p && pend_q[0].is_exc;
    e.req  = (m_mode == 1);
    e.addr = m_pc;
    e.seq  = m_next(m_pc);
    e.fv   = e.req && rdy && !ev && !rv && !have_p;
    e.fpc  = m_pc;
    exp_q.push_back(e);
    if (ev || p_exc)  tgt = EXC_W;
    else if (rv)      tgt = ra;
    else if (have_p)  tgt = pend_q[0].addr;
    else              tgt = m_next(m_pc);
    case (m_mode)
      0: begin
        model_latch(ev, rv, ra);
        m_mode = st ? 2 : 1;
      end
      1: begin
        if (rdy) begin
          m_pc = tgt;
          pend_q.delete();
          m_mode = st ? 2 : 1;
        end else begin
          model_latch(ev, rv, ra);
        end
      end
      default: begin
        if (ev || rv || have_p) begin
          m_pc = tgt;
          pend_q.delete();
        end
        if (!st) m_mode = 1;
      end
    endcase
    #3 last_fv = fetch_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redir_valid = 1'b0; exc_valid = 1'b0; imem_ready = 1'b0; redir_addr = '0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
  task automatic async_reset(input string tag);
    idle_inputs();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_fv"}, fetch_valid, 0);
    chk({tag, "_addr"}, imem_addr, INIT_W);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (imem_req !== e.req || imem_addr !== e.addr || seq_pc !== e.seq ||
          fetch_valid !== e.fv || (e.fv && fetch_pc !== e.fpc)) begin
        errors++;
        $display("FAIL scoreboard: got req=%b addr=%h fv=%b fpc=%h seq=%h expected req=%b addr=%h fv=%b fpc=%h seq=%h at %0t",
                 imem_req, imem_addr, fetch_valid, fetch_pc, seq_pc,
                 e.req, e.addr, e.fv, e.fpc, e.seq, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          r_st, r_rv, r_ev, r_rdy;
    logic [PW-1:0] r_ra;
    rst_n = 1'b0;
    idle_inputs();
    s_rst_n = 1'b0; s_stall = 1'b1; s_redir_valid = 1'b0; s_exc_valid = 1'b0;
    s_imem_ready = 1'b0; s_redir_addr = '0;
    model_reset();

    // Narrow instance: 6-bit word PC wraps from 0x3F to 0.
    repeat (2) @(posedge clk);
    #1 s_rst_n = 1'b1;
    chk("s_boot_req", s_imem_req, 0);
    @(posedge clk); #1;
    chk("s_hold_req", s_imem_req, 0);
    s_redir_valid = 1'b1; s_redir_addr = 6'h3F;
    @(posedge clk); #1;
    s_redir_valid = 1'b0; s_stall = 1'b0;
    chk("s_hold_load_req", s_imem_req, 0);
    @(posedge clk); #1;
    chk("s_wrap_req", s_imem_req, 1);
    chk("s_wrap_addr", s_imem_addr, 6'h3F);
    chk("s_wrap_seq", s_seq_pc, 6'h00);
    s_imem_ready = 1'b1;
    #1;
    chk("s_wrap_fv", s_fetch_valid, 1);
    chk("s_wrap_fpc", s_fetch_pc, 6'h3F);
    @(posedge clk); #1;
    s_imem_ready = 1'b0;
    chk("s_wrapped_addr", s_imem_addr, 6'h00);
    chk("s_wrapped_seq", s_seq_pc, 6'h01);

    // Main instance, while still in reset.
    chk("rst_req", imem_req, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_addr", imem_addr, INIT_W);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk("boot_req", imem_req, 0);

    // Free-running sequential fetch after release.
    cycle(0, 0, '0, 0, 1);
    chk("seq0_req", imem_req, 1);
    chk("seq0_addr", imem_addr, 0);
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 0, '0, 0, 1);
      chk("seq_fv", last_fv, 1);
      chk("seq_addr", imem_addr, i);
    end

    // Redirect while the request waits: address holds, fetch killed.
    cycle(0, 0, '0, 0, 0);
    chk("wait1_addr", imem_addr, 5);
    cycle(0, 1, 30'h40, 0, 0);
    chk("wait2_addr", imem_addr, 5);
    cycle(0, 0, '0, 0, 0);
    chk("wait3_addr", imem_addr, 5);
    cycle(0, 0, '0, 0, 1);
    chk("redir_kill_fv", last_fv, 0);
    chk("redir_addr", imem_addr, 30'h40);

    // Pending exception outranks a later redirect.
    cycle(0, 0, '0, 0, 0);
    cycle(0, 1, 30'h44, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 1, 30'h50, 0, 0);
    chk("exc_wait_addr", imem_addr, 30'h40);
    cycle(0, 0, '0, 0, 1);
    chk("exc_kill_fv", last_fv, 0);
    chk("exc_addr", imem_addr, EXC_W);

    // Same-cycle exception and redirect at handshake.
    cycle(0, 1, 30'h99, 1, 1);
    chk("both_fv", last_fv, 0);
    chk("both_addr", imem_addr, EXC_W);

    // Redirect during HOLD loads the PC without a request.
    cycle(1, 1, 30'h9, 0, 1);
    chk("hold9_req", imem_req, 0);
    chk("hold9_addr", imem_addr, 30'h9);
    cycle(1, 1, 30'h30, 0, 0);
    chk("hold_load_req", imem_req, 0);
    chk("hold_load_addr", imem_addr, 30'h30);
    cycle(1, 0, '0, 0, 0);
    chk("hold_stay_req", imem_req, 0);
    cycle(0, 0, '0, 0, 0);
    chk("hold_exit_req", imem_req, 1);
    chk("hold_exit_addr", imem_addr, 30'h30);
    cycle(0, 0, '0, 0, 1);
    chk("hold_fetch_fv", last_fv, 1);

    // Stall rising mid-request keeps the request until it completes.
    cycle(1, 0, '0, 0, 0);
    chk("stall_keep_req", imem_req, 1);
    chk("stall_keep_addr", imem_addr, 30'h31);
    cycle(1, 0, '0, 0, 1);
    chk("stall_done_fv", last_fv, 1);
    chk("stall_hold_req", imem_req, 0);
    chk("stall_hold_addr", imem_addr, 30'h32);
    cycle(0, 0, '0, 0, 0);

    // Asynchronous reset with a pending redirect: nothing replayed.
    cycle(0, 0, '0, 0, 0);
    cycle(0, 1, 30'h77, 0, 0);
    async_reset("midreset");
    cycle(0, 0, '0, 0, 1);
    chk("post_reset_addr", imem_addr, INIT_W);
    cycle(0, 0, '0, 0, 1);
    chk("post_reset_fv", last_fv, 1);
    chk("post_reset_next", imem_addr, 30'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      r_st  = ($urandom_range(0, 3) == 0);
      r_rv  = ($urandom_range(0, 6) == 0);
      r_ev  = ($urandom_range(0, 13) == 0);
      r_rdy = ($urandom_range(0, 4) < 3);
      r_ra  = ($urandom_range(0, 7) == 0) ? '1 : PW'($urandom());
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_reset");
      end
      cycle(r_st, r_rv, r_ra, r_ev, r_rdy);
    end

    idle_inputs();
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width; PC holds word address bits [ADDR_W-1:2].
REQ-002 Parameter INIT_ADDR, 32'h0000_0000, byte reset address (bits [1:0] ignored).
REQ-003 Parameter EXC_VECTOR, 32'h0000_0080, byte exception entry address (bits [1:0] ignored).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 stall  in  1  pipeline hold; no new fetch issued while high.
REQ-007 redir_valid  in  1  branch/jump redirect request, one-cycle pulse.
REQ-008 redir_addr  in  ADDR_W-2  redirect target word address.
REQ-009 exc_valid  in  1  exception request, one-cycle pulse; target EXC_VECTOR.
REQ-010 imem_req  out  1  fetch request to instruction memory.
REQ-011 imem_addr  out  ADDR_W-2  word address of current request (equals pc).
REQ-012 imem_ready  in  1  memory accepts/completes request this cycle.
REQ-013 fetch_valid  out  1  one-cycle pulse: instruction at fetch_pc delivered to decode.
REQ-014 fetch_pc  out  ADDR_W-2  word address of delivered instruction.
REQ-015 seq_pc  out  ADDR_W-2  pc+1 (link/next-sequential value), combinational from pc.

Function
REQ-016 States BOOT, FETCH, HOLD; encoding free.
REQ-017 BOOT: imem_req=0; next cycle -> FETCH (stall=0) or HOLD (stall=1).
REQ-018 FETCH: imem_req=1; imem_addr SHALL stay constant until a cycle with imem_ready=1 (handshake).
REQ-019 Handshake cycle: pc <= next target; -> HOLD if stall=1 else stay FETCH.
REQ-020 HOLD: imem_req=0, pc held; -> FETCH first cycle stall=0.
REQ-021 Next target priority at handshake: exc_valid this cycle or pending exception -> EXC_VECTOR; else redir_valid this cycle or pending redirect -> that address; else pc+1.
REQ-022 Event arriving in FETCH without imem_ready, or in BOOT, SHALL be latched into a single pending slot (pend_valid, pend_exc, pend_addr); pc unchanged.
REQ-023 Event arriving in HOLD SHALL load pc directly next cycle, clear pending slot, no memory side effect.
REQ-024 Pending slot overwrite: newer exception overwrites anything; newer redirect overwrites pending redirect, never pending exception.
REQ-025 Same-cycle exc_valid and redir_valid: exception wins, redirect discarded.
REQ-026 Pending slot cleared when consumed (handshake or HOLD load).
REQ-027 fetch_valid=1 on handshake cycle only if no event arrived this cycle and no pending event existed (otherwise fetched instruction is killed); fetch_pc=imem_addr that cycle.
REQ-028 pc+1 wraps modulo 2^(ADDR_W-2); all-ones pc sequences to 0.
REQ-029 stall rising while in FETCH without handshake SHALL NOT drop imem_req; request completes first, then HOLD.
REQ-030 fetch_valid, fetch_pc registered-free: driven combinationally from handshake cycle state.

Reset
REQ-031 rst_n=0 SHALL immediately force: state BOOT, pc=INIT_ADDR[ADDR_W-1:2], pending slot cleared, imem_req=0, fetch_valid=0.
REQ-032 Reset mid-request abandons it; no fetch_valid for it; first request after release is INIT_ADDR.
REQ-033 Release: BOOT lasts exactly one clock after first rising edge with rst_n=1.

Verification
REQ-034 Reset release, stall=0, imem_ready=1 always -> imem_addr 0,1,2,3 on consecutive cycles, fetch_valid each cycle from cycle 2.
REQ-035 imem_ready=0 for 3 cycles at pc=5, redir_valid pulse (addr 0x40) in 2nd wait cycle -> imem_addr stays 5, handshake gives fetch_valid=0, next imem_addr 0x40.
REQ-036 Same as 035 plus exc_valid one cycle later, then redirect 0x50 -> next imem_addr 0x20 (EXC_VECTOR word), 0x50 lost.
REQ-037 stall=1 in HOLD at pc=9, redir_valid addr 0x30 -> pc=0x30, imem_req stays 0 until stall=0, then imem_addr 0x30, fetch_valid=1 on its handshake.
REQ-038 ADDR_W=8, pc=6'h3F, ready=1 -> next imem_addr 0, seq_pc 0 while pc=0x3F.
REQ-039 rst_n asserted low mid-wait with pending redirect -> outputs reset same cycle (asynchronous); after release first imem_addr=INIT_ADDR, pending not replayed.
